// File: rtl/axi4_stream_sc_pkt_fifo_if.sv
// rtl/axi4_stream_sc_pkt_fifo_if.sv - AXI4-Stream bundle with master/slave modports
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
                  input  tready);
  modport slave  (input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
                  output tready);
endinterface

// File: rtl/axi4_stream_sc_pkt_fifo.sv
// rtl/axi4_stream_sc_pkt_fifo.sv - single-clock AXI4-Stream packet FIFO
// Store-and-forward or cut-through, with overflow / error packet drop and statistics.
module axi4_stream_sc_pkt_fifo #(
  parameter int BUFFER_DEPTH       = 64,
  parameter int DATA_WIDTH         = 32,
  parameter int USER_WIDTH         = 1,
  parameter int DEST_WIDTH         = 1,
  parameter int ID_WIDTH           = 1,
  parameter bit STORE_AND_FORWARD  = 1'b1,
  parameter bit ALLOW_BACKPRESSURE = 1'b0,
  parameter bit DROP_ON_ERROR      = 1'b0,
  parameter int ALMOST_FULL_LVL    = BUFFER_DEPTH - 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  axi4_stream_if.slave                    pkt_i,
  axi4_stream_if.master                   pkt_o,
  output logic [$clog2(BUFFER_DEPTH):0]   used_words_o,
  output logic [$clog2(BUFFER_DEPTH):0]   pkts_o,
  output logic                            almost_full_o,
  output logic                            drop_pulse_o,
  output logic [31:0]                     drop_cnt_o
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int WW = DATA_WIDTH + 2 * KW + 1 + USER_WIDTH + DEST_WIDTH + ID_WIDTH;
  localparam bit DROP_MODE = STORE_AND_FORWARD && !ALLOW_BACKPRESSURE;
  localparam bit ERR_MODE  = STORE_AND_FORWARD && DROP_ON_ERROR;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(BUFFER_DEPTH);
  localparam logic [AW:0] AF_LVL  = (AW + 1)'(ALMOST_FULL_LVL);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  if (!STORE_AND_FORWARD && !ALLOW_BACKPRESSURE) begin : g_illegal_cfg
    $error("axi4_stream_sc_pkt_fifo: cut-through requires ALLOW_BACKPRESSURE=1");
  end

  typedef enum logic {ST_ACCEPT, ST_DROP} state_t;
  state_t state_q, state_d;

  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [WW-1:0] mem [BUFFER_DEPTH];
  logic [WW-1:0] in_word, ram_q, out_q;
  logic          s1_v, out_v;
  logic          full, in_hs, out_hs, out_last_hs, err_beat;
  logic          wr_en, commit, rewind, avail, rd_req, out_load;
  logic [AW:0]   rewind_cnt, used_d;

  assign full         = used_words_o == DEPTH_C;
  assign pkt_i.tready = ALLOW_BACKPRESSURE ? !full : 1'b1;
  assign in_hs        = pkt_i.tvalid && pkt_i.tready;
  assign err_beat     = ERR_MODE && pkt_i.tlast && pkt_i.tuser[0];
  assign in_word      = {pkt_i.tdata, pkt_i.tstrb, pkt_i.tkeep, pkt_i.tlast,
                         pkt_i.tuser, pkt_i.tdest, pkt_i.tid};

  // Overflow is judged on the registered count, so a same-cycle read does not rescue the beat.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    rewind  = 1'b0;
    if (in_hs) begin
      unique case (state_q)
        ST_ACCEPT: begin
          if (DROP_MODE && full) begin
            rewind = 1'b1;
            if (!pkt_i.tlast) state_d = ST_DROP;
          end else if (err_beat) begin
            rewind = 1'b1;
          end else begin
            wr_en  = 1'b1;
            commit = pkt_i.tlast;
          end
        end
        ST_DROP: begin
          if (pkt_i.tlast) state_d = ST_ACCEPT;
        end
      endcase
    end
  end

  assign rewind_cnt  = rewind ? (wr_ptr - commit_ptr) : '0;
  assign used_d      = used_words_o + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, out_hs} - rewind_cnt;
  assign avail       = STORE_AND_FORWARD ? (rd_ptr != commit_ptr) : (rd_ptr != wr_ptr);
  assign out_hs      = out_v && pkt_o.tready;
  assign out_last_hs = out_hs && pkt_o.tlast;
  // Two-stage read pipeline: RAM read register, then the output register.
  assign out_load    = s1_v && (!out_v || out_hs);
  assign rd_req      = avail && (!s1_v || out_load);

  always_ff @(posedge clk_i) begin
    if (wr_en)  mem[wr_ptr[AW-1:0]] <= in_word;
    if (rd_req) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_ACCEPT;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      s1_v          <= 1'b0;
      out_v         <= 1'b0;
      out_q         <= '0;
      used_words_o  <= '0;
      pkts_o        <= '0;
      almost_full_o <= 1'b0;
      drop_pulse_o  <= 1'b0;
      drop_cnt_o    <= '0;
    end else begin
      state_q <= state_d;
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit)     commit_ptr <= wr_ptr + PTR_ONE;
      if (rd_req)     rd_ptr <= rd_ptr + PTR_ONE;

      if (rd_req)        s1_v <= 1'b1;
      else if (out_load) s1_v <= 1'b0;
      if (out_load) begin
        out_q <= ram_q;
        out_v <= 1'b1;
      end else if (out_hs) begin
        out_v <= 1'b0;
      end

      used_words_o  <= used_d;
      almost_full_o <= used_d >= AF_LVL;
      unique case ({commit, out_last_hs})
        2'b10:   pkts_o <= pkts_o + PTR_ONE;
        2'b01:   pkts_o <= pkts_o - PTR_ONE;
        default: pkts_o <= pkts_o;
      endcase
      drop_pulse_o <= rewind;
      if (rewind && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end

  assign pkt_o.tvalid = out_v;
  assign {pkt_o.tdata, pkt_o.tstrb, pkt_o.tkeep, pkt_o.tlast,
          pkt_o.tuser, pkt_o.tdest, pkt_o.tid} = out_q;
endmodule
